// File: rtl/cnn_acc_pkg.sv
// -----------------------------------------------------------------------------
// cnn_acc_pkg
// Shared constants and state types for the partial-sum accumulator.
//   CNN_PSUM_W : width of one signed partial sum from a PE
//   CNN_ACC_W  : signed accumulator width (PSUM_W + 8 guard bits)
//   CNN_OUT_W  : width of the signed requantized output
//   state_e    : top-level job state
//   phase_e    : sub-phase inside ACCUM (beat intake, result load, present)
// -----------------------------------------------------------------------------
package cnn_acc_pkg;

  localparam int CNN_PSUM_W = 25;
  localparam int CNN_ACC_W  = CNN_PSUM_W + 8;
  localparam int CNN_OUT_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    PH_BEAT = 2'd0,
    PH_LOAD = 2'd1,
    PH_SHOW = 2'd2
  } phase_e;

endpackage

// File: rtl/psum_requant.sv
// -----------------------------------------------------------------------------
// psum_requant
// Combinational requantizer: round half up, arithmetic right shift, optional
// ReLU, saturate to the signed OUT_W range.
// Optional feature macro: PSUM_RELU_EN (negative rounded results forced to 0
// before saturation; ReLU itself never raises sat_o).
// Ports:
//   acc_i   in  ACC_W  signed accumulator value
//   shift_i in  5      right-shift amount (0 = pass through)
//   data_o  out OUT_W  signed requantized result
//   sat_o   out 1      result was clamped to the OUT_W range
// -----------------------------------------------------------------------------
module psum_requant
  import cnn_acc_pkg::*;
#(
  parameter int ACC_W = CNN_ACC_W,
  parameter int OUT_W = CNN_OUT_W
) (
  input  logic signed [ACC_W-1:0] acc_i,
  input  logic        [4:0]       shift_i,
  output logic signed [OUT_W-1:0] data_o,
  output logic                    sat_o
);

  // One extra bit so the rounding offset can never overflow the sum.
  localparam int EXT_W = ACC_W + 1;
  localparam logic signed [EXT_W-1:0] MAX_V = EXT_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [EXT_W-1:0] MIN_V = EXT_W'(-(2 ** (OUT_W - 1)));

  logic signed [EXT_W-1:0] ext;
  logic signed [EXT_W-1:0] rnd;
  logic signed [EXT_W-1:0] shifted;
  logic signed [EXT_W-1:0] pre_sat;

  always_comb begin
    ext = {acc_i[ACC_W-1], acc_i};
    rnd = '0;
    if (shift_i != 5'd0) begin
      rnd = EXT_W'(1) << (shift_i - 5'd1);
    end
    shifted = (ext + rnd) >>> shift_i;
`ifdef PSUM_RELU_EN
    pre_sat = shifted[EXT_W-1] ? '0 : shifted;
`else
    pre_sat = shifted;
`endif
    data_o = pre_sat[OUT_W-1:0];
    sat_o  = 1'b0;
    if (pre_sat > MAX_V) begin
      data_o = MAX_V[OUT_W-1:0];
      sat_o  = 1'b1;
    end else if (pre_sat < MIN_V) begin
      data_o = MIN_V[OUT_W-1:0];
      sat_o  = 1'b1;
    end
  end

endmodule

// File: rtl/psum_accumulator.sv
// -----------------------------------------------------------------------------
// psum_accumulator
// Accumulates cfg_groups signed partial sums per output pixel, requantizes the
// sum and presents it with a valid/ready handshake, for cfg_pixels pixels per
// job.
// Optional feature macro: PSUM_RELU_EN (handled inside psum_requant).
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for start; cfg latched and job cleared on start
//   ACCUM | PH_BEAT: taking beats; PH_LOAD: requant into out_data;
//         | PH_SHOW: raise out_valid and move to OUT
//   OUT   | holding out_data/out_valid until out_ready
//
// Ports:
//   clk, rst (async, active-high)
//   start, cfg_groups[8], cfg_pixels[16], cfg_shift[5] : job setup
//   psum_valid, p_sum[PSUM_W], psum_ready               : beat input
//   out_valid, out_data[OUT_W], out_ready               : result output
//   busy, sat_flag                                      : status
// -----------------------------------------------------------------------------
module psum_accumulator
  import cnn_acc_pkg::*;
#(
  parameter int PSUM_W = CNN_PSUM_W,
  parameter int ACC_W  = CNN_ACC_W,
  parameter int OUT_W  = CNN_OUT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic        [7:0]        cfg_groups,
  input  logic        [15:0]       cfg_pixels,
  input  logic        [4:0]        cfg_shift,
  input  logic                     psum_valid,
  input  logic signed [PSUM_W-1:0] p_sum,
  output logic                     psum_ready,
  output logic                     out_valid,
  output logic signed [OUT_W-1:0]  out_data,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     sat_flag
);

  state_e                   state_q;
  phase_e                   phase_q;
  logic        [7:0]        groups_q;
  logic        [15:0]       pixels_q;
  logic        [4:0]        shift_q;
  logic        [7:0]        grp_cnt_q;
  logic        [15:0]       pix_cnt_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  acc_d;
  logic                     psum_ready_q;
  logic                     out_valid_q;
  logic signed [OUT_W-1:0]  out_data_q;
  logic                     sat_q;
  logic signed [OUT_W-1:0]  rq_data;
  logic                     rq_sat;

  assign acc_d = acc_q + {{(ACC_W - PSUM_W){p_sum[PSUM_W-1]}}, p_sum};

  psum_requant #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W)
  ) u_requant (
    .acc_i   (acc_q),
    .shift_i (shift_q),
    .data_o  (rq_data),
    .sat_o   (rq_sat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      phase_q      <= PH_BEAT;
      groups_q     <= 8'd1;
      pixels_q     <= 16'd1;
      shift_q      <= '0;
      grp_cnt_q    <= '0;
      pix_cnt_q    <= '0;
      acc_q        <= '0;
      psum_ready_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      sat_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            groups_q     <= (cfg_groups == 8'd0) ? 8'd1 : cfg_groups;
            pixels_q     <= (cfg_pixels == 16'd0) ? 16'd1 : cfg_pixels;
            shift_q      <= cfg_shift;
            acc_q        <= '0;
            grp_cnt_q    <= '0;
            pix_cnt_q    <= '0;
            sat_q        <= 1'b0;
            psum_ready_q <= 1'b1;
            phase_q      <= PH_BEAT;
            state_q      <= ACCUM;
          end
        end
        ACCUM: begin
          case (phase_q)
            PH_BEAT: begin
              if (psum_valid && psum_ready_q) begin
                acc_q     <= acc_d;
                grp_cnt_q <= grp_cnt_q + 8'd1;
                if (grp_cnt_q == groups_q - 8'd1) begin
                  psum_ready_q <= 1'b0;
                  phase_q      <= PH_LOAD;
                end
              end
            end
            PH_LOAD: begin
              out_data_q <= rq_data;
              if (rq_sat) begin
                sat_q <= 1'b1;
              end
              phase_q <= PH_SHOW;
            end
            PH_SHOW: begin
              out_valid_q <= 1'b1;
              phase_q     <= PH_BEAT;
              state_q     <= OUT;
            end
            default: phase_q <= PH_BEAT;
          endcase
        end
        OUT: begin
          if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
            pix_cnt_q   <= pix_cnt_q + 16'd1;
            if (pix_cnt_q == pixels_q - 16'd1) begin
              state_q <= IDLE;
            end else begin
              acc_q        <= '0;
              grp_cnt_q    <= '0;
              psum_ready_q <= 1'b1;
              state_q      <= ACCUM;
            end
          end
        end
        default: begin
          state_q      <= IDLE;
          phase_q      <= PH_BEAT;
          psum_ready_q <= 1'b0;
          out_valid_q  <= 1'b0;
        end
      endcase
    end
  end

  assign psum_ready = psum_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign sat_flag   = sat_q;
  assign busy       = (state_q != IDLE);

endmodule
